// File: rtl/wmr_burst_seq.sv
// Burst sequencer: expands one go request into a series of single-word
// start/finish four-phase handshakes towards a downstream write/read FSM,
// walking consecutive addresses and incrementing write data per word.
// Read bursts capture each returned word and keep a running XOR.
// Optional watchdog: define WMR_SEQ_TIMEOUT_EN to abort a stalled handshake
// after TIMEOUT_CYC cycles in REQ or REL (sets sticky error, still pulses done).
module wmr_burst_seq #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              burst_wr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        burst_len,
  input  logic [DATA_W-1:0] seed_data,
  input  logic              finish,
  input  logic [DATA_W-1:0] rd_data,
  output logic              start,
  output logic              wren,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rd_xor,
  output logic              error
);

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MAX_LEN = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A zero watchdog limit would abort every word immediately
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("wmr_burst_seq: TIMEOUT_CYC must be at least 1");
  end

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   seed_q, seed_d;

  logic                start_d, wren_d, busy_d, done_d, rd_valid_d, error_d;
  logic [ADDR_W-1:0]   address_d;
  logic [DATA_W-1:0]   write_data_d, rd_word_d, rd_xor_d;

  logic [LEN_W-1:0]    len_clamped;
  logic [LEN_W-1:0]    idx_next;
  logic                more_words;
  logic                tmo_hit;

  // Lengths above the supported maximum saturate
  assign len_clamped = (burst_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : burst_len;
  assign idx_next    = LEN_W'({1'b0, idx_q}) + LEN_W'(1);
  assign more_words  = (idx_next < len_q);

`ifdef WMR_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC));

  // Watchdog count: restart on every entry to REQ/REL, count while waiting
  always_comb begin
    tmo_d = tmo_q;
    if ((state_d == S_REQ || state_d == S_REL) && state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == S_REQ || state_q == S_REL) && !tmo_hit) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_d         = wr_q;
    base_d       = base_q;
    len_d        = len_q;
    seed_d       = seed_q;
    start_d      = start;
    wren_d       = wren;
    address_d    = address;
    write_data_d = write_data;
    rd_valid_d   = 1'b0;
    rd_word_d    = rd_word;
    rd_xor_d     = rd_xor;
    error_d      = error;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          wr_d         = burst_wr;
          base_d       = base_addr;
          len_d        = len_clamped;
          seed_d       = seed_data;
          idx_d        = '0;
          rd_xor_d     = '0;
          error_d      = 1'b0;
          wren_d       = burst_wr;
          address_d    = base_addr;
          write_data_d = seed_data;
          if (len_clamped == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            start_d = 1'b1;
          end
        end
      end

      S_REQ: begin
        if (tmo_hit) begin
          error_d = 1'b1;
          start_d = 1'b0;
          state_d = S_DONE;
        end else if (finish) begin
          start_d = 1'b0;
          state_d = S_REL;
          if (!wr_q) begin
            rd_word_d  = rd_data;
            rd_xor_d   = rd_xor ^ rd_data;
            rd_valid_d = 1'b1;
          end
        end
      end

      S_REL: begin
        if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (!finish) begin
          if (more_words) begin
            idx_d        = IDX_W'(idx_next);
            address_d    = base_q + ADDR_W'(idx_next);
            write_data_d = seed_q + DATA_W'(idx_next);
            start_d      = 1'b1;
            state_d      = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and burst context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      base_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start      <= 1'b0;
      wren       <= 1'b0;
      address    <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_word    <= '0;
      rd_xor     <= '0;
      error      <= 1'b0;
    end else begin
      start      <= start_d;
      wren       <= wren_d;
      address    <= address_d;
      write_data <= write_data_d;
      busy       <= busy_d;
      done       <= done_d;
      rd_valid   <= rd_valid_d;
      rd_word    <= rd_word_d;
      rd_xor     <= rd_xor_d;
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_wmr_burst_seq.sv
// Directed bench for wmr_burst_seq with a configurable-latency handshake
// responder that logs every word it completes.
module tb_wmr_burst_seq;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned TMO    = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              go;
  logic              burst_wr;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        burst_len;
  logic [DATA_W-1:0] seed_data;
  logic              finish;
  logic [DATA_W-1:0] rd_data = '0;
  logic              start, wren, busy, done, rd_valid, error;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data, rd_word, rd_xor;

  wmr_burst_seq #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .burst_wr   (burst_wr),
    .base_addr  (base_addr),
    .burst_len  (burst_len),
    .seed_data  (seed_data),
    .finish     (finish),
    .rd_data    (rd_data),
    .start      (start),
    .wren       (wren),
    .address    (address),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .rd_valid   (rd_valid),
    .rd_word    (rd_word),
    .rd_xor     (rd_xor),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responder: raises finish req_dly+1 edges after seeing start, drops it
  // rel_dly+1 edges after seeing start fall; logs each completed word.
  int                req_dly = 0;
  int                rel_dly = 0;
  bit                resp_en = 1'b1;
  int                req_cnt = 0;
  int                rel_cnt = 0;
  int                log_n   = 0;
  int                rd_base = 0;
  logic [ADDR_W-1:0] log_addr [256];
  logic [DATA_W-1:0] log_data [256];
  logic              log_wr   [256];
  logic [DATA_W-1:0] rd_vals  [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish  <= 1'b0;
      req_cnt <= 0;
      rel_cnt <= 0;
    end else if (resp_en) begin
      if (!finish) begin
        if (start) begin
          if (req_cnt >= req_dly) begin
            finish          <= 1'b1;
            req_cnt         <= 0;
            log_addr[log_n] <= address;
            log_data[log_n] <= write_data;
            log_wr[log_n]   <= wren;
            rd_data         <= rd_vals[(log_n - rd_base) & 15];
            log_n           <= log_n + 1;
          end else begin
            req_cnt <= req_cnt + 1;
          end
        end
      end else if (!start) begin
        if (rel_cnt >= rel_dly) begin
          finish  <= 1'b0;
          rel_cnt <= 0;
        end else begin
          rel_cnt <= rel_cnt + 1;
        end
      end
    end
  end

  // Launch a burst at the current (negedge) time and watch it until done.
  // Cycle numbers count negedges after the edge that samples go.
  task automatic run_burst(input logic wr, input logic [ADDR_W-1:0] base,
                           input logic [3:0] len, input logic [DATA_W-1:0] seed,
                           input bit poke, output int done_cyc, output int valid_cnt,
                           output int start_max, output int start_total);
    int run;
    run         = 0;
    done_cyc    = -1;
    valid_cnt   = 0;
    start_max   = 0;
    start_total = 0;
    go          = 1'b1;
    burst_wr    = wr;
    base_addr   = base;
    burst_len   = len;
    seed_data   = seed;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      go = poke && (cyc == 3 || cyc == 10);
      if (start) begin
        run++;
        start_total++;
        if (run > start_max) start_max = run;
      end else begin
        run = 0;
      end
      if (rd_valid) valid_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    go = 1'b0;
  endtask

  int  dc, vc, smax, stot, l0;
  bit  seen, hit, saw_done, saw_busy_low;

  initial begin
    rst_n     = 1'b0;
    go        = 1'b0;
    burst_wr  = 1'b0;
    base_addr = '0;
    burst_len = '0;
    seed_data = '0;
    for (int k = 0; k < 16; k++) rd_vals[k] = '0;

    repeat (3) @(negedge clk);
    check("rst_start",   start,      0);
    check("rst_busy",    busy,       0);
    check("rst_done",    done,       0);
    check("rst_error",   error,      0);
    check("rst_address", address,    0);
    check("rst_wdata",   write_data, 0);
    check("rst_rd_xor",  rd_xor,     0);

    // Write burst right after reset release: go taken on the first edge
    rst_n = 1'b1;
    l0    = log_n;
    run_burst(1'b1, 3'd2, 4'd3, 32'h10, 1'b0, dc, vc, smax, stot);
    check("wr_done_cyc", dc, 13);
    check("wr_words",    log_n - l0, 3);
    check("wr_addr0",    log_addr[l0],     2);
    check("wr_data0",    log_data[l0],     32'h10);
    check("wr_addr1",    log_addr[l0 + 1], 3);
    check("wr_data1",    log_data[l0 + 1], 32'h11);
    check("wr_addr2",    log_addr[l0 + 2], 4);
    check("wr_data2",    log_data[l0 + 2], 32'h12);
    check("wr_wren",     log_wr[l0 + 2],   1);
    check("wr_start_max", smax, 2);
    @(negedge clk);
    check("wr_idle_busy", busy, 0);

    // Read burst wrapping past the top address
    l0         = log_n;
    rd_base    = log_n;
    rd_vals[0] = 32'hA5;
    rd_vals[1] = 32'h0F;
    run_burst(1'b0, 3'd7, 4'd2, 32'h0, 1'b0, dc, vc, smax, stot);
    check("rd_done_cyc", dc, 9);
    check("rd_addr0",    log_addr[l0],     7);
    check("rd_addr1",    log_addr[l0 + 1], 0);
    check("rd_wren",     log_wr[l0],       0);
    check("rd_valid_n",  vc, 2);
    check("rd_word",     rd_word, 32'h0F);
    check("rd_xor",      rd_xor,  32'hAA);
    @(negedge clk);

    // Zero-length burst: immediate done, no handshake, rd_xor cleared
    l0 = log_n;
    run_burst(1'b1, 3'd4, 4'd0, 32'h5, 1'b0, dc, vc, smax, stot);
    check("len0_done_cyc", dc, 1);
    check("len0_start",    stot, 0);
    check("len0_words",    log_n - l0, 0);
    check("len0_rd_xor",   rd_xor, 0);
    @(negedge clk);

    // Oversize length clamps to 8 words; data wraps modulo 2^DATA_W
    l0 = log_n;
    run_burst(1'b1, 3'd0, 4'd12, 32'hFFFF_FFFE, 1'b0, dc, vc, smax, stot);
    check("len12_done_cyc", dc, 33);
    check("len12_words",    log_n - l0, 8);
    check("len12_last_addr", log_addr[l0 + 7], 7);
    check("len12_last_data", log_data[l0 + 7], 32'h5);
    @(negedge clk);

    // Address wrap 6,7,0,1
    l0 = log_n;
    run_burst(1'b1, 3'd6, 4'd4, 32'h0, 1'b0, dc, vc, smax, stot);
    check("wrap_done_cyc", dc, 17);
    check("wrap_a0", log_addr[l0],     6);
    check("wrap_a1", log_addr[l0 + 1], 7);
    check("wrap_a2", log_addr[l0 + 2], 0);
    check("wrap_a3", log_addr[l0 + 3], 1);
    @(negedge clk);

    // Slow responder with stray go pulses while busy
    req_dly = 4;
    rel_dly = 3;
    l0      = log_n;
    run_burst(1'b1, 3'd3, 4'd2, 32'h100, 1'b1, dc, vc, smax, stot);
    check("slow_done_cyc",  dc, 23);
    check("slow_start_max", smax, 6);
    check("slow_words",     log_n - l0, 2);
    check("slow_data1",     log_data[l0 + 1], 32'h101);
    saw_done = 1'b0;
    saw_busy_low = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy) saw_busy_low = 1'b0;
      if (done) saw_done = 1'b1;
    end
    check("slow_no_requeue", saw_busy_low, 1);
    check("slow_no_done",    saw_done, 0);
    check("slow_no_words",   log_n - l0, 2);
    req_dly = 0;
    rel_dly = 0;

    // Reset asserted during REL of word 1
    go        = 1'b1;
    burst_wr  = 1'b1;
    base_addr = 3'd1;
    burst_len = 4'd3;
    seed_data = 32'h40;
    seen      = 1'b0;
    hit       = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      if (start && address == 3'd2) seen = 1'b1;
      else if (seen && !start) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_rel_reached", hit, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_start",   start,   0);
    check("midrst_busy",    busy,    0);
    check("midrst_address", address, 0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", saw_done, 0);
    rst_n = 1'b1;
    l0    = log_n;
    run_burst(1'b1, 3'd5, 4'd2, 32'h77, 1'b0, dc, vc, smax, stot);
    check("postrst_done_cyc", dc, 9);
    check("postrst_addr0",    log_addr[l0],     5);
    check("postrst_data1",    log_data[l0 + 1], 32'h78);
    @(negedge clk);

    // Responder never answers
    resp_en = 1'b0;
`ifdef WMR_SEQ_TIMEOUT_EN
    run_burst(1'b1, 3'd0, 4'd1, 32'h0, 1'b0, dc, vc, smax, stot);
    check("tmo_done_cyc", dc, TMO + 2);
    check("tmo_error",    error, 1);
    check("tmo_start",    start, 0);
    @(negedge clk);
    check("tmo_sticky",   error, 1);
`else
    go        = 1'b1;
    burst_wr  = 1'b1;
    base_addr = 3'd0;
    burst_len = 4'd1;
    seed_data = '0;
    saw_done  = 1'b0;
    repeat (300) begin
      @(negedge clk);
      go = 1'b0;
      if (done) saw_done = 1'b1;
    end
    check("hang_busy",  busy,     1);
    check("hang_error", error,    0);
    check("hang_start", start,    1);
    check("hang_done",  saw_done, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wmr_burst_seq.md
WMR_BURST_SEQ -- requirements
Module: wmr_burst_seq

Interface
REQ-001 Parameter DATA_W, default 32, sets the width of write data and read data.
REQ-002 Parameter ADDR_W, default 3, sets the register address width.
REQ-003 Parameter TIMEOUT_CYC, default 255, is the watchdog limit in cycles; it is used only when WMR_SEQ_TIMEOUT_EN is defined.
REQ-004 Port clk: input, 1 bit, sole clock; all logic on the rising edge.
REQ-005 Port rst_n: input, 1 bit, reset, asynchronous, active-low.
REQ-006 Port go: input, 1 bit, burst request; sampled only in IDLE.
REQ-007 Port burst_wr: input, 1 bit; 1 = write burst, 0 = read burst.
REQ-008 Port base_addr: input, ADDR_W bits, first word address.
REQ-009 Port burst_len: input, 4 bits, word count 0..8; values 9..15 are clamped to 8.
REQ-010 Port seed_data: input, DATA_W bits, write data for word 0.
REQ-011 Port finish: input, 1 bit, completion flag from the downstream write/read handshake FSM.
REQ-012 Port rd_data: input, DATA_W bits, read data from the register store; valid while finish=1.
REQ-013 Port start: output, 1 bit, request to the downstream FSM.
REQ-014 Port wren: output, 1 bit, write enable to the downstream FSM.
REQ-015 Port address: output, ADDR_W bits, word address to the downstream FSM.
REQ-016 Port write_data: output, DATA_W bits, write data to the downstream FSM.
REQ-017 Port busy: output, 1 bit; 1 in any state other than IDLE.
REQ-018 Port done: output, 1 bit, one-cycle pulse at burst end.
REQ-019 Port rd_valid: output, 1 bit, one-cycle pulse per captured read word.
REQ-020 Port rd_word: output, DATA_W bits, last captured read word.
REQ-021 Port rd_xor: output, DATA_W bits, running XOR of the read words in the current burst.
REQ-022 Port error: output, 1 bit, sticky timeout flag.

Function
REQ-023 The state machine SHALL have states IDLE, REQ, REL and DONE; all outputs SHALL be registered.
REQ-024 In IDLE with go=1, the block SHALL latch burst_wr, base_addr, clamped burst_len and seed_data, clear rd_xor, and clear error.
REQ-025 On go acceptance with burst_len=0, the next state SHALL be DONE and start SHALL never assert.
REQ-026 On go acceptance with burst_len>0, the next state SHALL be REQ, with start=1 in the cycle after go is sampled.
REQ-027 In REQ, start SHALL be 1, wren SHALL equal the latched burst_wr, address SHALL be (base_addr+i) mod 2^ADDR_W, and write_data SHALL be (seed_data+i) mod 2^DATA_W, where i is the word index.
REQ-028 REQ SHALL remain until finish=1 is sampled, then the block SHALL move to REL.
REQ-029 For a read burst, on that same edge the block SHALL load rd_word from rd_data, XOR rd_data into rd_xor, and pulse rd_valid.
REQ-030 In REL, start SHALL be 0 and address, wren and write_data SHALL hold.
REQ-031 REL SHALL remain until finish=0 is sampled (four-phase handshake); then, if i+1 < len, the block SHALL increment i and return to REQ, otherwise it SHALL move to DONE.
REQ-032 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL be 1, then the block SHALL return to IDLE.
REQ-033 go while busy=1 SHALL be ignored; no queueing.
REQ-034 Address wrap: base_addr=6 with len=4 SHALL produce the address sequence 6, 7, 0, 1.
REQ-035 A burst of N words SHALL take 1 + sum over words of (REQ cycles + REL cycles) + 1 cycles.
REQ-036 Against a single-cycle-response FSM, each word SHALL take 4 cycles.

Reset
REQ-037 While rst_n=0, asynchronously: state=IDLE, i=0, and start, wren, busy, done, rd_valid and error all 0.
REQ-038 While rst_n=0, asynchronously: address, write_data, rd_word and rd_xor all 0.
REQ-039 Reset mid-burst SHALL drop start immediately, with no done pulse.
REQ-040 After rst_n rises, the first go SHALL be accepted on the first rising edge.

Configuration
REQ-041 With WMR_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ or REL.
REQ-042 With WMR_SEQ_TIMEOUT_EN defined, if that counter reaches TIMEOUT_CYC in REQ or REL, the block SHALL set error=1, force start=0, and go to DONE (done still pulses).
REQ-043 With WMR_SEQ_TIMEOUT_EN undefined, there SHALL be no counter, error SHALL be tied 0, and the block SHALL wait indefinitely.

Verification
REQ-044 Write burst: go with burst_wr=1, base=2, len=3, seed=0x10, single-cycle responder -> writes (2,0x10), (3,0x11), (4,0x12); done at cycle 14; busy low at cycle 15.
REQ-045 Read burst: base=7, len=2, rd_data=0xA5 then 0x0F -> addresses 7, 0; rd_valid x2; rd_word=0x0F; rd_xor=0xAA.
REQ-046 len=0: go -> done one cycle later, start never 1; len=12 -> exactly 8 words.
REQ-047 Slow responder: finish delayed 5 cycles in REQ and 3 in REL -> start stays high 6 cycles, the next word waits for finish=0, and go pulses while busy are ignored.
REQ-048 rst_n low during REL of word 1 -> start, busy and address 0 asynchronously, no done; a new go after release starts cleanly.
REQ-049 With WMR_SEQ_TIMEOUT_EN defined and finish held 0 -> error=1 and done after TIMEOUT_CYC cycles; without the macro -> busy stays 1 and error stays 0.
